// File: rtl/mro_alloc_pkg.sv
// Shared constants and slot layout for the mro_alloc entry allocator.
package mro_alloc_pkg;

    localparam int MRO_ENTRIES_DEF = 4;
    localparam int MRO_DATA_W_DEF  = 32;

    typedef struct packed {
        logic                      is_rd_rsp;
        logic [MRO_DATA_W_DEF-1:0] data;
    } mro_slot_t;

endpackage

// File: rtl/mro_alloc_slot.sv
// One allocator slot: valid, type and payload flops with set/clear/write enables.
// Payload is deliberately not reset; only valid and type are.
module mro_alloc_slot
    import mro_alloc_pkg::*;
#(
    parameter int DATA_W = MRO_DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_i,
    input  logic              clr_i,
    input  logic              is_rd_rsp_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic              is_rd_rsp_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_d, valid_q;
    logic              is_rd_rsp_d, is_rd_rsp_q;
    logic [DATA_W-1:0] data_d, data_q;

    // set and clr never hit the same slot in one cycle: a freed slot is not free
    always_comb begin
        valid_d     = valid_q;
        is_rd_rsp_d = is_rd_rsp_q;
        data_d      = data_q;
        if (set_i) begin
            valid_d     = 1'b1;
            is_rd_rsp_d = is_rd_rsp_i;
            data_d      = data_i;
        end else if (clr_i) begin
            valid_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            is_rd_rsp_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            is_rd_rsp_q <= is_rd_rsp_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign valid_o     = valid_q;
    assign is_rd_rsp_o = is_rd_rsp_q;
    assign data_o      = data_q;

endmodule

// File: rtl/mro_alloc.sv
// Entry allocator and payload buffer feeding the age-matrix tracker from the write side.
// Optional MRO_ALLOC_CHK_EN adds the ErrSticky tracker-consistency output.
module mro_alloc
    import mro_alloc_pkg::*;
#(
    parameter int MRO_MSB = MRO_ENTRIES_DEF - 1,
    parameter int DATA_W  = MRO_DATA_W_DEF
) (
    input  logic                        Clk,
    input  logic                        RstN,
    input  logic                        InValid,
    output logic                        InReady,
    input  logic                        InIsRdRsp,
    input  logic [DATA_W-1:0]           InData,
    output logic                        EnAlloc,
    output logic [MRO_MSB:0]            NextAlloc,
    output logic [MRO_MSB:0]            Dealloc,
    output logic [MRO_MSB:0]            Mask0,
    output logic [MRO_MSB:0]            Mask1,
    input  logic [MRO_MSB:0]            Oldest0,
    input  logic [MRO_MSB:0]            Oldest1,
    output logic                        Out0Valid,
    input  logic                        Out0Ready,
    output logic [DATA_W-1:0]           Out0Data,
    output logic                        Out1Valid,
    input  logic                        Out1Ready,
    output logic [DATA_W-1:0]           Out1Data,
    output logic [$clog2(MRO_MSB+1):0]  Count
`ifdef MRO_ALLOC_CHK_EN
   ,output logic                        ErrSticky
`endif
);

    localparam int ENTRIES = MRO_MSB + 1;
    localparam int CNT_W   = $clog2(ENTRIES) + 1;

    logic [MRO_MSB:0]  slot_valid;
    logic [MRO_MSB:0]  slot_is_rd_rsp;
    logic [DATA_W-1:0] slot_data [ENTRIES];
    logic [MRO_MSB:0]  free;
    logic [MRO_MSB:0]  first_free;
    logic [MRO_MSB:0]  alloc_onehot;
    logic              pop0, pop1;
    logic              rst_done_d, rst_done_q;
    logic [CNT_W-1:0]  count_d, count_q;

    for (genvar i = 0; i < ENTRIES; i++) begin : g_slot
        mro_alloc_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk         (Clk),
            .rst_n       (RstN),
            .set_i       (alloc_onehot[i]),
            .clr_i       (Dealloc[i]),
            .is_rd_rsp_i (InIsRdRsp),
            .data_i      (InData),
            .valid_o     (slot_valid[i]),
            .is_rd_rsp_o (slot_is_rd_rsp[i]),
            .data_o      (slot_data[i])
        );
    end

    assign free = ~slot_valid;

    always_comb begin
        first_free = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (free[i] && (first_free == '0)) begin
                first_free[i] = 1'b1;
            end
        end
    end

    // NextAlloc is held at zero until the block is out of reset
    assign NextAlloc    = rst_done_q ? first_free : '0;
    assign InReady      = rst_done_q & (|free);
    assign EnAlloc      = InValid & InReady;
    assign alloc_onehot = EnAlloc ? NextAlloc : '0;

    assign Mask0     = slot_valid & slot_is_rd_rsp;
    assign Mask1     = slot_valid & ~slot_is_rd_rsp;
    assign Out0Valid = |Mask0;
    assign Out1Valid = |Mask1;
    assign pop0      = Out0Valid & Out0Ready;
    assign pop1      = Out1Valid & Out1Ready;
    assign Dealloc   = (pop0 ? Oldest0 : '0) | (pop1 ? Oldest1 : '0);

    always_comb begin
        Out0Data = '0;
        Out1Data = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (Oldest0[i]) Out0Data = Out0Data | slot_data[i];
            if (Oldest1[i]) Out1Data = Out1Data | slot_data[i];
        end
    end

    always_comb begin
        rst_done_d = 1'b1;
        count_d    = count_q + CNT_W'(EnAlloc) - CNT_W'(pop0) - CNT_W'(pop1);
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            rst_done_q <= 1'b0;
            count_q    <= '0;
        end else begin
            rst_done_q <= rst_done_d;
            count_q    <= count_d;
        end
    end

    assign Count = count_q;

`ifdef MRO_ALLOC_CHK_EN
    logic err_d, err_q;
    logic chk_viol;

    always_comb begin
        chk_viol = 1'b0;
        if (Out0Valid) chk_viol = chk_viol | !$onehot(Oldest0) | (|(Oldest0 & ~Mask0));
        else           chk_viol = chk_viol | (|Oldest0);
        if (Out1Valid) chk_viol = chk_viol | !$onehot(Oldest1) | (|(Oldest1 & ~Mask1));
        else           chk_viol = chk_viol | (|Oldest1);
        err_d = err_q | chk_viol;
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign ErrSticky = err_q;
`endif

endmodule

// File: tb/tb_mro_alloc.sv
// Directed self-checking bench for mro_alloc acting as ingress source, tracker and drain sinks.
module tb_mro_alloc;

    logic        Clk = 1'b0;
    logic        RstN;
    logic        InValid, InIsRdRsp;
    logic [31:0] InData;
    logic        InReady, EnAlloc;
    logic [3:0]  NextAlloc, Dealloc, Mask0, Mask1, Oldest0, Oldest1;
    logic        Out0Valid, Out0Ready, Out1Valid, Out1Ready;
    logic [31:0] Out0Data, Out1Data;
    logic [2:0]  Count;
`ifdef MRO_ALLOC_CHK_EN
    logic        ErrSticky;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    mro_alloc #(.MRO_MSB(3), .DATA_W(32)) dut (
        .Clk       (Clk),
        .RstN      (RstN),
        .InValid   (InValid),
        .InReady   (InReady),
        .InIsRdRsp (InIsRdRsp),
        .InData    (InData),
        .EnAlloc   (EnAlloc),
        .NextAlloc (NextAlloc),
        .Dealloc   (Dealloc),
        .Mask0     (Mask0),
        .Mask1     (Mask1),
        .Oldest0   (Oldest0),
        .Oldest1   (Oldest1),
        .Out0Valid (Out0Valid),
        .Out0Ready (Out0Ready),
        .Out0Data  (Out0Data),
        .Out1Valid (Out1Valid),
        .Out1Ready (Out1Ready),
        .Out1Data  (Out1Data),
        .Count     (Count)
`ifdef MRO_ALLOC_CHK_EN
       ,.ErrSticky (ErrSticky)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        RstN = 1'b0; InValid = 1'b1; InIsRdRsp = 1'b0; InData = '0;
        Oldest0 = '0; Oldest1 = '0; Out0Ready = 1'b0; Out1Ready = 1'b0;
        #12;
        check("rst_inready", 32'(InReady), 32'h0);
        check("rst_enalloc", 32'(EnAlloc), 32'h0);
        check("rst_nextalloc", 32'(NextAlloc), 32'h0);
        check("rst_mask0", 32'(Mask0), 32'h0);
        check("rst_mask1", 32'(Mask1), 32'h0);
        check("rst_out_valid", {30'b0, Out1Valid, Out0Valid}, 32'h0);
        check("rst_dealloc", 32'(Dealloc), 32'h0);
        check("rst_count", 32'(Count), 32'h0);

        InValid = 1'b0;
        #1 RstN = 1'b1;
        #1 check("rel_inready_before_edge", 32'(InReady), 32'h0);
        tick();
        check("rel_inready_after_edge", 32'(InReady), 32'h1);

        // A (RdRsp), B (cmd), C (RdRsp) back to back
        InValid = 1'b1; InIsRdRsp = 1'b1; InData = 32'hAAAA_0001;
        #1 check("alloc_a_next", 32'(NextAlloc), 32'h1);
        check("alloc_a_en", 32'(EnAlloc), 32'h1);
        tick();
        InIsRdRsp = 1'b0; InData = 32'hBBBB_0002;
        #1 check("alloc_b_next", 32'(NextAlloc), 32'h2);
        tick();
        InIsRdRsp = 1'b1; InData = 32'hCCCC_0003;
        #1 check("alloc_c_next", 32'(NextAlloc), 32'h4);
        tick();
        InValid = 1'b0;
        #1 check("abc_mask0", 32'(Mask0), 32'h5);
        check("abc_mask1", 32'(Mask1), 32'h2);
        check("abc_count", 32'(Count), 32'h3);

        Oldest0 = 4'b0001; Oldest1 = 4'b0010;
        #1 check("abc_out0data", Out0Data, 32'hAAAA_0001);
        check("abc_out1data", Out1Data, 32'hBBBB_0002);
        check("abc_noready_dealloc", 32'(Dealloc), 32'h0);

        // fill the last slot with D (cmd)
        InValid = 1'b1; InIsRdRsp = 1'b0; InData = 32'hDDDD_0004;
        #1 check("alloc_d_next", 32'(NextAlloc), 32'h8);
        tick();
        InValid = 1'b0;
        #1 check("full_count", 32'(Count), 32'h4);
        check("full_inready", 32'(InReady), 32'h0);
        check("full_nextalloc", 32'(NextAlloc), 32'h0);
        check("full_mask1", 32'(Mask1), 32'hA);

        // pop A while full: InReady stays low this cycle
        Out0Ready = 1'b1;
        #1 check("full_pop_dealloc", 32'(Dealloc), 32'h1);
        check("full_pop_inready_same", 32'(InReady), 32'h0);
        check("full_pop_out0data", Out0Data, 32'hAAAA_0001);
        tick();
        Out0Ready = 1'b0; Oldest0 = 4'b0100;
        #1 check("after_pop_inready", 32'(InReady), 32'h1);
        check("after_pop_nextalloc", 32'(NextAlloc), 32'h1);
        check("after_pop_count", 32'(Count), 32'h3);
        check("after_pop_mask0", 32'(Mask0), 32'h4);

        // both ports pop C and B together
        Out0Ready = 1'b1; Out1Ready = 1'b1;
        #1 check("dual_dealloc", 32'(Dealloc), 32'h6);
        check("dual_out0data", Out0Data, 32'hCCCC_0003);
        check("dual_out1data", Out1Data, 32'hBBBB_0002);
        tick();
        Out0Ready = 1'b0; Out1Ready = 1'b0; Oldest0 = 4'b0000; Oldest1 = 4'b1000;
        #1 check("dual_count", 32'(Count), 32'h1);
        check("dual_out0valid", 32'(Out0Valid), 32'h0);
        check("dual_mask1", 32'(Mask1), 32'h8);
        check("dual_out1data_d", Out1Data, 32'hDDDD_0004);

        // E (RdRsp) into slot 0, giving Count = 2
        InValid = 1'b1; InIsRdRsp = 1'b1; InData = 32'hEEEE_0005;
        #1 check("alloc_e_next", 32'(NextAlloc), 32'h1);
        tick();
        Oldest0 = 4'b0001;
        InData = 32'hFFFF_0006;
        Out0Ready = 1'b1;
        #1 check("ap_count_before", 32'(Count), 32'h2);
        check("ap_nextalloc", 32'(NextAlloc), 32'h2);
        check("ap_dealloc", 32'(Dealloc), 32'h1);
        check("ap_disjoint", 32'(Dealloc & NextAlloc), 32'h0);
        check("ap_enalloc", 32'(EnAlloc), 32'h1);
        tick();
        Out0Ready = 1'b0; InValid = 1'b0; Oldest0 = 4'b0010;
        #1 check("ap_count_after", 32'(Count), 32'h2);
        check("ap_mask0", 32'(Mask0), 32'h2);
        check("ap_out0data_f", Out0Data, 32'hFFFF_0006);

        // G (cmd) into slot 0 -> 3 valid, then asynchronous reset
        InValid = 1'b1; InIsRdRsp = 1'b0; InData = 32'h6666_0007;
        #1 check("alloc_g_next", 32'(NextAlloc), 32'h1);
        tick();
        InValid = 1'b0;
        #1 check("pre_rst_count", 32'(Count), 32'h3);
        RstN = 1'b0;
        Oldest0 = '0; Oldest1 = '0;
        #1 check("midrst_mask0", 32'(Mask0), 32'h0);
        check("midrst_mask1", 32'(Mask1), 32'h0);
        check("midrst_count", 32'(Count), 32'h0);
        check("midrst_inready", 32'(InReady), 32'h0);
        check("midrst_out_valid", {30'b0, Out1Valid, Out0Valid}, 32'h0);
        tick();
        RstN = 1'b1;
        #1 check("rerel_inready_before", 32'(InReady), 32'h0);
        tick();
        check("rerel_inready_after", 32'(InReady), 32'h1);
        check("rerel_nextalloc", 32'(NextAlloc), 32'h1);

`ifdef MRO_ALLOC_CHK_EN
        InValid = 1'b1; InIsRdRsp = 1'b1; InData = 32'h1234_5678;
        tick();
        InValid = 1'b0; Oldest0 = 4'b0001;
        #1 check("chk_clean", 32'(ErrSticky), 32'h0);
        Oldest0 = 4'b0011;
        tick();
        check("chk_set", 32'(ErrSticky), 32'h1);
        Oldest0 = 4'b0001;
        tick();
        check("chk_hold", 32'(ErrSticky), 32'h1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
